// File: rtl/smpl_pkg.sv
// ---------------------------------------------------------------------------
// smpl_pkg
//   Shared types and helpers for the sample trigger source.
//   - SMPL_W           : width of the sample bus toward the display renderers
//   - smpl_src_state_t : frame controller states
//   - edge_hit()       : level-crossing test between two consecutive kept
//                        samples, on zero-extended operands
// ---------------------------------------------------------------------------
package smpl_pkg;

  localparam int SMPL_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } smpl_src_state_t;

  // Rising:  prev < lvl <= cur.  Falling: prev > lvl >= cur.
  // Without a previous kept sample there is no edge to detect.
  function automatic logic edge_hit(input logic              rising,
                                    input logic              has_prev,
                                    input logic [SMPL_W-1:0] prev,
                                    input logic [SMPL_W-1:0] cur,
                                    input logic [SMPL_W-1:0] lvl);
    logic hit;
    if (rising) begin
      hit = (prev < lvl) && (lvl <= cur);
    end else begin
      hit = (prev > lvl) && (lvl >= cur);
    end
    return has_prev && hit;
  endfunction

endpackage

// File: rtl/smpl_decimator.sv
// ---------------------------------------------------------------------------
// smpl_decimator
//   Keeps 1 of every (decim+1) valid ADC samples and registers the kept
//   sample one cycle after its adc_valid strobe.
//   Ports:
//     clkSmpl   in   sample clock
//     n_reset   in   asynchronous active-low reset
//     adc_valid in   raw ADC sample strobe
//     adc       in   raw ADC sample (AN bits, unsigned)
//     decim     in   decimation ratio minus one
//     d_valid   out  kept-sample strobe
//     d_data    out  kept sample (held between strobes)
// ---------------------------------------------------------------------------
module smpl_decimator #(
  parameter int AN   = 12,
  parameter int DECW = 8
) (
  input  logic            clkSmpl,
  input  logic            n_reset,
  input  logic            adc_valid,
  input  logic [AN-1:0]   adc,
  input  logic [DECW-1:0] decim,
  output logic            d_valid,
  output logic [AN-1:0]   d_data
);

  logic [DECW-1:0] cnt_q, cnt_d;
  logic            d_valid_q, d_valid_d;
  logic [AN-1:0]   d_data_q, d_data_d;
  logic            keep;

  // decim is sampled only at reload, so a ratio change never cuts short
  // the skip run already in progress.
  always_comb begin
    cnt_d     = cnt_q;
    keep      = adc_valid && (cnt_q == '0);
    d_valid_d = keep;
    d_data_d  = d_data_q;
    if (adc_valid) begin
      if (keep) begin
        cnt_d    = decim;
        d_data_d = adc;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q     <= '0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
    end
  end

  assign d_valid = d_valid_q;
  assign d_data  = d_data_q;

endmodule

// File: rtl/smpl_trigger_source.sv
// ---------------------------------------------------------------------------
// smpl_trigger_source
//   Producer end of the smpl_valid/smpl_req/smpl stream. Decimates the raw
//   ADC stream, waits for a level/edge trigger (or an auto timeout), then
//   streams up to SIZE consecutive kept samples while smpl_req stays high.
//   Ports:
//     clkSmpl     in   sample clock
//     n_reset     in   asynchronous active-low reset
//     adc_valid   in   raw ADC sample strobe
//     adc         in   raw ADC sample (AN bits, unsigned)
//     decim       in   keep 1 of (decim+1) valid ADC samples
//     trig_level  in   trigger threshold
//     trig_rising in   1 = rising edge, 0 = falling edge
//     auto_mode   in   force a frame after TOUT cycles without a trigger
//     smpl_req    in   consumer ready, held high across a frame
//     smpl_valid  out  sample strobe toward consumer
//     smpl        out  sample, zero-extended to SMPL_W bits
//     triggered   out  pulse with the first sample of a frame
//     trig_auto   out  pulse with triggered when the frame was forced
// ---------------------------------------------------------------------------
module smpl_trigger_source
  import smpl_pkg::*;
#(
  parameter int AN   = 12,
  parameter int SIZE = 1024,
  parameter int DECW = 8,
  parameter int TOUT = 2**20
) (
  input  logic              clkSmpl,
  input  logic              n_reset,
  input  logic              adc_valid,
  input  logic [AN-1:0]     adc,
  input  logic [DECW-1:0]   decim,
  input  logic [AN-1:0]     trig_level,
  input  logic              trig_rising,
  input  logic              auto_mode,
  input  logic              smpl_req,
  output logic              smpl_valid,
  output logic [SMPL_W-1:0] smpl,
  output logic              triggered,
  output logic              trig_auto
);

  localparam int FW = $clog2(SIZE + 1);
  localparam int TW = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [FW-1:0] FRAME_LEN = FW'(SIZE);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TOUT - 1);

  // Timeout counter parks at TMO_MAX instead of wrapping.
  function automatic logic [TW-1:0] tmo_sat_inc(input logic [TW-1:0] v);
    return (v == TMO_MAX) ? v : v + 1'b1;
  endfunction

  logic          d_valid;
  logic [AN-1:0] d_data;

  smpl_decimator #(
    .AN   (AN),
    .DECW (DECW)
  ) u_decim (
    .clkSmpl   (clkSmpl),
    .n_reset   (n_reset),
    .adc_valid (adc_valid),
    .adc       (adc),
    .decim     (decim),
    .d_valid   (d_valid),
    .d_data    (d_data)
  );

  smpl_src_state_t   state_q, state_d;
  logic [AN-1:0]     lvl_q, lvl_d;
  logic              rise_q, rise_d;
  logic              auto_q, auto_d;
  logic [AN-1:0]     prev_q, prev_d;
  logic              has_prev_q, has_prev_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              auto_pend_q, auto_pend_d;
  logic              smpl_valid_q, smpl_valid_d;
  logic [SMPL_W-1:0] smpl_q, smpl_d;
  logic              triggered_q, triggered_d;
  logic              trig_auto_q, trig_auto_d;

  logic              accept;
  logic [FW-1:0]     frame_inc;
  logic              hit;

  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    rise_d       = rise_q;
    auto_d       = auto_q;
    prev_d       = prev_q;
    has_prev_d   = has_prev_q;
    tmo_d        = tmo_q;
    frame_d      = frame_q;
    auto_pend_d  = auto_pend_q;
    smpl_valid_d = 1'b0;
    smpl_d       = smpl_q;
    triggered_d  = 1'b0;
    trig_auto_d  = 1'b0;

    accept    = smpl_valid_q && smpl_req;
    frame_inc = frame_q + FW'(accept);
    hit       = d_valid && edge_hit(rise_q, has_prev_q, SMPL_W'(prev_q),
                                    SMPL_W'(d_data), SMPL_W'(lvl_q));

    unique case (state_q)
      IDLE: begin
        // Trigger setup is frozen for the whole arm/stream cycle.
        lvl_d       = trig_level;
        rise_d      = trig_rising;
        auto_d      = auto_mode;
        tmo_d       = '0;
        frame_d     = '0;
        has_prev_d  = 1'b0;
        auto_pend_d = 1'b0;
        if (smpl_req) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        // A falling smpl_req outranks a coincident trigger.
        if (!smpl_req) begin
          state_d = IDLE;
        end else if (hit) begin
          // The trigger sample itself opens the frame.
          state_d      = STREAM;
          smpl_valid_d = 1'b1;
          smpl_d       = SMPL_W'(d_data);
          triggered_d  = 1'b1;
        end else if (auto_q && (tmo_q == TMO_MAX)) begin
          // Forced frame starts with the next kept sample; the pulses ride
          // on that sample.
          state_d     = STREAM;
          auto_pend_d = 1'b1;
        end else begin
          if (d_valid) begin
            prev_d     = d_data;
            has_prev_d = 1'b1;
          end
          tmo_d = tmo_sat_inc(tmo_q);
        end
      end

      STREAM: begin
        frame_d = frame_inc;
        // Leaving is decided before forwarding, so neither a truncated nor
        // a full frame emits one sample too many.
        if (!smpl_req || (frame_inc == FRAME_LEN)) begin
          state_d = IDLE;
        end else if (d_valid) begin
          smpl_valid_d = 1'b1;
          smpl_d       = SMPL_W'(d_data);
          if (auto_pend_q) begin
            triggered_d = 1'b1;
            trig_auto_d = 1'b1;
            auto_pend_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      lvl_q        <= '0;
      rise_q       <= 1'b0;
      auto_q       <= 1'b0;
      prev_q       <= '0;
      has_prev_q   <= 1'b0;
      tmo_q        <= '0;
      frame_q      <= '0;
      auto_pend_q  <= 1'b0;
      smpl_valid_q <= 1'b0;
      smpl_q       <= '0;
      triggered_q  <= 1'b0;
      trig_auto_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lvl_q        <= lvl_d;
      rise_q       <= rise_d;
      auto_q       <= auto_d;
      prev_q       <= prev_d;
      has_prev_q   <= has_prev_d;
      tmo_q        <= tmo_d;
      frame_q      <= frame_d;
      auto_pend_q  <= auto_pend_d;
      smpl_valid_q <= smpl_valid_d;
      smpl_q       <= smpl_d;
      triggered_q  <= triggered_d;
      trig_auto_q  <= trig_auto_d;
    end
  end

  assign smpl_valid = smpl_valid_q;
  assign smpl       = smpl_q;
  assign triggered  = triggered_q;
  assign trig_auto  = trig_auto_q;

endmodule

// File: tb/tb_smpl_trigger_source.sv
// ---------------------------------------------------------------------------
// tb_smpl_trigger_source
//   Directed scenarios plus a randomized run, checked every cycle against a
//   frame-level reference model, with scenario-level checks on frame shape.
// ---------------------------------------------------------------------------
module tb_smpl_trigger_source;

  localparam int AN   = 12;
  localparam int SIZE = 1024;
  localparam int DECW = 8;
  localparam int TOUT = 64;

  logic            clkSmpl = 1'b0;
  logic            n_reset = 1'b0;
  logic            adc_valid = 1'b0;
  logic [AN-1:0]   adc = '0;
  logic [DECW-1:0] decim = '0;
  logic [AN-1:0]   trig_level = '0;
  logic            trig_rising = 1'b1;
  logic            auto_mode = 1'b0;
  logic            smpl_req = 1'b0;
  logic            smpl_valid;
  logic [15:0]     smpl;
  logic            triggered;
  logic            trig_auto;

  smpl_trigger_source #(
    .AN   (AN),
    .SIZE (SIZE),
    .DECW (DECW),
    .TOUT (TOUT)
  ) dut (
    .clkSmpl     (clkSmpl),
    .n_reset     (n_reset),
    .adc_valid   (adc_valid),
    .adc         (adc),
    .decim       (decim),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .auto_mode   (auto_mode),
    .smpl_req    (smpl_req),
    .smpl_valid  (smpl_valid),
    .smpl        (smpl),
    .triggered   (triggered),
    .trig_auto   (trig_auto)
  );

  always #5 clkSmpl = ~clkSmpl;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: mode 0 = waiting for request, 1 = waiting for
  // trigger, 2 = delivering a frame.
  // ------------------------------------------------------------------
  int m_mode, m_skip, m_dd, m_lvl, m_prev, m_timer, m_acc, e_smpl;
  bit m_dv, m_rise, m_auto, m_hasprev, m_pend;
  bit e_valid, e_trig, e_auto;

  task automatic model_reset();
    m_mode = 0; m_skip = 0; m_dd = 0; m_lvl = 0; m_prev = 0; m_timer = 0;
    m_acc = 0; e_smpl = 0; m_dv = 0; m_rise = 0; m_auto = 0; m_hasprev = 0;
    m_pend = 0; e_valid = 0; e_trig = 0; e_auto = 0;
  endtask

  function automatic bit crossed(bit rise, bit has, int prev, int cur, int lvl);
    if (!has) return 0;
    if (rise) return (prev < lvl) && (cur >= lvl);
    return (prev > lvl) && (cur <= lvl);
  endfunction

  task automatic model_edge();
    bit nk, ov, ot, oa;
    int nd, os;
    if (!n_reset) begin
      model_reset();
      return;
    end
    nk = 0; nd = m_dd;
    if (adc_valid) begin
      if (m_skip == 0) begin
        nk = 1; nd = int'(adc); m_skip = int'(decim);
      end else begin
        m_skip--;
      end
    end
    ov = 0; ot = 0; oa = 0; os = e_smpl;
    if (m_mode == 0) begin
      m_lvl = int'(trig_level); m_rise = trig_rising; m_auto = auto_mode;
      m_timer = 0; m_acc = 0; m_hasprev = 0; m_pend = 0;
      if (smpl_req) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!smpl_req) begin
        m_mode = 0;
      end else if (m_dv && crossed(m_rise, m_hasprev, m_prev, m_dd, m_lvl)) begin
        m_mode = 2; ov = 1; os = m_dd; ot = 1;
      end else if (m_auto && m_timer == TOUT - 1) begin
        m_mode = 2; m_pend = 1;
      end else begin
        if (m_dv) begin
          m_prev = m_dd; m_hasprev = 1;
        end
        if (m_timer < TOUT - 1) m_timer++;
      end
    end else begin
      if (e_valid && smpl_req) m_acc++;
      if (!smpl_req || m_acc == SIZE) begin
        m_mode = 0;
      end else if (m_dv) begin
        ov = 1; os = m_dd;
        if (m_pend) begin
          ot = 1; oa = 1; m_pend = 0;
        end
      end
    end
    m_dv = nk; m_dd = nd;
    e_valid = ov; e_smpl = os; e_trig = ot; e_auto = oa;
  endtask

  // ------------------------------------------------------------------
  // Per-cycle stepping, comparison and frame statistics
  // ------------------------------------------------------------------
  int cyc = 0;
  int obs_valid, obs_trig, obs_auto, first_smpl, last_smpl, trig_cyc;
  int last_vcyc, min_gap, step_bad, exp_step;
  bit have_last;

  task automatic clear_stats(input int step_v);
    obs_valid = 0; obs_trig = 0; obs_auto = 0; first_smpl = -1; last_smpl = -1;
    trig_cyc = -1; last_vcyc = 0; min_gap = 1000000; step_bad = 0;
    exp_step = step_v; have_last = 0;
  endtask

  task automatic step();
    @(posedge clkSmpl);
    model_edge();
    cyc++;
    #1;
    check_val($sformatf("cyc%0d", cyc),
              {13'd0, smpl_valid, triggered, trig_auto, (smpl_valid ? smpl : 16'h0)},
              {13'd0, e_valid, e_trig, e_auto, (e_valid ? 16'(e_smpl) : 16'h0)});
    if (smpl_valid) begin
      if (have_last) begin
        if (((int'(smpl) - last_smpl) & 'hFFF) != exp_step) step_bad++;
        if (cyc - last_vcyc < min_gap) min_gap = cyc - last_vcyc;
      end
      have_last = 1; last_smpl = int'(smpl); last_vcyc = cyc; obs_valid++;
    end
    if (triggered) begin
      obs_trig++;
      if (obs_trig == 1) begin
        first_smpl = int'(smpl); trig_cyc = cyc;
      end
    end
    if (trig_auto) obs_auto++;
  endtask

  task automatic drive(input bit v, input int val);
    adc_valid = v;
    adc = AN'(val);
    step();
  endtask

  task automatic go_idle();
    smpl_req = 1'b0;
    repeat (3) drive(1'b0, 0);
  endtask

  task automatic set_cfg(input int d, input int lvl, input bit rise, input bit au);
    decim = DECW'(d); trig_level = AN'(lvl); trig_rising = rise; auto_mode = au;
  endtask

  function automatic int gen(input int kind, input int start, input int i);
    if (kind == 0) return (start + i) & 'hFFF;
    if (kind == 1) return (i < 4096) ? ('hFFF - i) : ((i - 4096) & 'hFFF);
    return start;
  endfunction

  // Runs a waveform until one full frame has been seen (plus a short tail)
  // or the cycle budget runs out.
  task automatic run_frame(input int kind, input int start, input int budget);
    int extra = 0;
    for (int i = 0; i < budget; i++) begin
      drive(1'b1, gen(kind, start, i));
      if (obs_valid >= SIZE) begin
        extra++;
        if (extra > 3) break;
      end
    end
  endtask

  initial begin
    int v;
    int raise_cyc;
    model_reset();
    #2;
    check_val("rst_valid", 32'(smpl_valid), 32'd0);
    check_val("rst_trig",  32'(triggered),  32'd0);
    check_val("rst_auto",  32'(trig_auto),  32'd0);
    check_val("rst_smpl",  32'(smpl),       32'd0);
    #10 n_reset = 1'b1;

    // 1: rising ramp, every sample kept
    set_cfg(0, 'h800, 1'b1, 1'b0);
    go_idle();
    clear_stats(1);
    smpl_req = 1'b1;
    for (int i = 0; i < 3300; i++) drive(1'b1, i);
    check_val("s1_trig_cnt", 32'(obs_trig), 32'd1);
    check_val("s1_first", 32'(first_smpl), 32'h800);
    check_val("s1_count", 32'(obs_valid), 32'(SIZE));
    check_val("s1_last", 32'(last_smpl), 32'hBFF);
    check_val("s1_step", 32'(step_bad), 32'd0);

    // 2: same ramp, 1 of 4 kept
    set_cfg(3, 'h800, 1'b1, 1'b0);
    go_idle();
    clear_stats(4);
    smpl_req = 1'b1;
    run_frame(0, 'h700, 6000);
    check_val("s2_trig_cnt", 32'(obs_trig), 32'd1);
    check_val("s2_first", 32'(first_smpl), 32'h800);
    check_val("s2_count", 32'(obs_valid), 32'(SIZE));
    check_val("s2_step", 32'(step_bad), 32'd0);
    check_val("s2_gap_ge4", 32'(min_gap >= 4), 32'd1);

    // 3: falling triangle
    set_cfg(0, 'h400, 1'b0, 1'b0);
    go_idle();
    clear_stats('hFFF);
    smpl_req = 1'b1;
    run_frame(1, 0, 6000);
    check_val("s3_trig_cnt", 32'(obs_trig), 32'd1);
    check_val("s3_first", 32'(first_smpl), 32'h400);
    check_val("s3_count", 32'(obs_valid), 32'(SIZE));
    check_val("s3_last", 32'(last_smpl), 32'h001);

    // 4: auto trigger on a flat input
    set_cfg(0, 'h800, 1'b1, 1'b1);
    go_idle();
    clear_stats(0);
    raise_cyc = cyc;
    smpl_req = 1'b1;
    run_frame(2, 'h100, 3000);
    check_val("s4_auto_cnt", 32'(obs_auto), 32'd1);
    check_val("s4_trig_cnt", 32'(obs_trig), 32'd1);
    check_val("s4_delay", 32'(trig_cyc - (raise_cyc + 2)), 32'd64);
    check_val("s4_first", 32'(first_smpl), 32'h100);
    check_val("s4_count", 32'(obs_valid), 32'(SIZE));
    check_val("s4_step", 32'(step_bad), 32'd0);

    // 5: truncate a frame by dropping smpl_req, then re-raise it
    set_cfg(0, 'h800, 1'b1, 1'b0);
    go_idle();
    clear_stats(1);
    smpl_req = 1'b1;
    v = 'h700;
    for (int i = 0; i < 1000 && obs_valid < 100; i++) begin
      drive(1'b1, v); v++;
    end
    check_val("s5_count", 32'(obs_valid), 32'd100);
    smpl_req = 1'b0;
    drive(1'b1, v); v++;
    check_val("s5_drop_valid", 32'(smpl_valid), 32'd0);
    repeat (3) begin
      drive(1'b1, v); v++;
    end
    check_val("s5_no_extra", 32'(obs_valid), 32'd100);
    smpl_req = 1'b1;
    clear_stats(1);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, v); v++;
    end
    check_val("s5_rearm_valid", 32'(obs_valid), 32'd0);
    check_val("s5_rearm_trig", 32'(obs_trig), 32'd0);

    // 6: asynchronous reset in the middle of a frame
    go_idle();
    clear_stats(1);
    smpl_req = 1'b1;
    v = 'h700;
    for (int i = 0; i < 1000 && obs_valid < 50; i++) begin
      drive(1'b1, v); v++;
    end
    check_val("s6_pre_valid", 32'(smpl_valid), 32'd1);
    #3 n_reset = 1'b0;
    #1;
    check_val("s6_rst_valid", 32'(smpl_valid), 32'd0);
    check_val("s6_rst_trig", 32'(triggered), 32'd0);
    check_val("s6_rst_auto", 32'(trig_auto), 32'd0);
    model_reset();
    #2 n_reset = 1'b1;
    clear_stats(1);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, v); v++;
    end
    check_val("s6_post_valid", 32'(obs_valid), 32'd0);
    for (int i = 0; i < 5000 && obs_trig == 0; i++) begin
      drive(1'b1, v); v++;
    end
    check_val("s6_new_trig", 32'(obs_trig), 32'd1);
    check_val("s6_new_first", 32'(first_smpl), 32'h800);

    // 7: randomized traffic, configuration churn and occasional resets
    go_idle();
    clear_stats(0);
    smpl_req = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(199) == 0) begin
        set_cfg(int'($urandom_range(3)), int'($urandom_range(4095)),
                1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      if ($urandom_range(299) == 0) smpl_req = ~smpl_req;
      if ($urandom_range(2999) == 0) begin
        #3 n_reset = 1'b0;
        #1;
        check_val("s7_rst_valid", 32'(smpl_valid), 32'd0);
        model_reset();
        #1 n_reset = 1'b1;
      end
      drive($urandom_range(3) != 0, int'($urandom_range(4095)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
